// File: rtl/phy_init_multi_pkg.sv
// Shared definitions for the multi-PHY init block.
//  - phy_state_t : per-channel sequencing state
//  - STRAP_W     : width of one channel's strap word {addr[4:0], rx_dv, rxd[7:0]}
//  - *_LSB/_BIT  : field offsets inside a strap word
//  - pack_strap  : builds a strap word from its fields
package phy_init_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_HOLD,
    S_WAIT,
    S_READY
  } phy_state_t;

  localparam int unsigned STRAP_W  = 14;
  localparam int unsigned RXD_LSB  = 0;
  localparam int unsigned RXDV_BIT = 8;
  localparam int unsigned ADDR_LSB = 9;

  function automatic logic [STRAP_W-1:0] pack_strap(input logic [4:0] addr,
                                                    input logic       rx_dv,
                                                    input logic [7:0] rxd);
    logic [STRAP_W-1:0] s;
    s = '0;
    s[ADDR_LSB +: 5] = addr;
    s[RXDV_BIT]      = rx_dv;
    s[RXD_LSB +: 8]  = rxd;
    return s;
  endfunction

endpackage

// File: rtl/phy_init_multi_if.sv
// Control/status bundle between the board top level and phy_init_multi.
//  master : top level / controller side (drives enables, reinit pulses, straps)
//  slave  : phy_init_multi (drives PHY pin levels, strap values, ready flags)
interface phy_init_multi_if #(
  parameter int unsigned NUM_PHY = 2
);

  logic [NUM_PHY-1:0]                        chan_en;
  logic [NUM_PHY-1:0]                        reinit_req;
  logic [NUM_PHY*phy_init_pkg::STRAP_W-1:0]  strap_cfg;
  logic [NUM_PHY-1:0]                        phy_hw_rst;
  logic [NUM_PHY-1:0]                        phy_strap_oe;
  logic [NUM_PHY*phy_init_pkg::STRAP_W-1:0]  phy_strap_out;
  logic [NUM_PHY-1:0]                        phy_ready;
  logic                                      all_ready;

  modport master (
    output chan_en, reinit_req, strap_cfg,
    input  phy_hw_rst, phy_strap_oe, phy_strap_out, phy_ready, all_ready
  );

  modport slave (
    input  chan_en, reinit_req, strap_cfg,
    output phy_hw_rst, phy_strap_oe, phy_strap_out, phy_ready, all_ready
  );

endinterface

// File: rtl/phy_strap_seq.sv
// One PHY channel: reset / strap-hold / settle sequencer with its own counter and
// strap register. All outputs are registered.
//  clk_50        50 MHz clock
//  reset_n       synchronous active-low reset (forces S_RST, latches straps)
//  chan_en       0 = park channel in S_IDLE with PHY held in reset
//  reinit_req    1-cycle restart pulse (ignored in S_IDLE)
//  strap_cfg     strap word sampled on entry to S_RST
//  phy_hw_rst    PHY reset pin level (0 = in reset)
//  phy_strap_oe  1 = drive strap pins
//  phy_strap_out latched strap word
//  phy_ready     channel configured and released
module phy_strap_seq
  import phy_init_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 500000,
  parameter int unsigned HOLD_CYCLES  = 50,
  parameter int unsigned READY_CYCLES = 250000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               chan_en,
  input  logic               reinit_req,
  input  logic [STRAP_W-1:0] strap_cfg,
  output logic               phy_hw_rst,
  output logic               phy_strap_oe,
  output logic [STRAP_W-1:0] phy_strap_out,
  output logic               phy_ready
);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_CYCLES - 1);

  phy_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state         <= S_RST;
      cnt           <= '0;
      phy_hw_rst    <= 1'b0;
      phy_strap_oe  <= 1'b1;
      phy_ready     <= 1'b0;
      phy_strap_out <= strap_cfg;
    end else if (!chan_en) begin
      state        <= S_IDLE;
      cnt          <= '0;
      phy_hw_rst   <= 1'b0;
      phy_strap_oe <= 1'b0;
      phy_ready    <= 1'b0;
    end else if (reinit_req && (state != S_IDLE)) begin
      state         <= S_RST;
      cnt           <= '0;
      phy_hw_rst    <= 1'b0;
      phy_strap_oe  <= 1'b1;
      phy_ready     <= 1'b0;
      phy_strap_out <= strap_cfg;
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_RST;
          cnt           <= '0;
          phy_hw_rst    <= 1'b0;
          phy_strap_oe  <= 1'b1;
          phy_ready     <= 1'b0;
          phy_strap_out <= strap_cfg;
        end
        S_RST: begin
          if (cnt == RST_LAST) begin
            state      <= S_HOLD;
            cnt        <= '0;
            phy_hw_rst <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state        <= S_WAIT;
            cnt          <= '0;
            phy_strap_oe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == READY_LAST) begin
            state     <= S_READY;
            cnt       <= '0;
            phy_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READY: begin
          state <= S_READY;
        end
        default: begin
          state        <= S_IDLE;
          cnt          <= '0;
          phy_hw_rst   <= 1'b0;
          phy_strap_oe <= 1'b0;
          phy_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_init_multi.sv
// Hardware reset and configuration-strap sequencing for NUM_PHY GigE PHYs.
// One phy_strap_seq per channel; this level only adds the all_ready reduction.
//  clk_50   50 MHz clock
//  reset_n  synchronous active-low reset
//  bus      phy_init_multi_if slave: chan_en, reinit_req, strap_cfg in;
//           phy_hw_rst, phy_strap_oe, phy_strap_out, phy_ready, all_ready out
module phy_init_multi
  import phy_init_pkg::*;
#(
  parameter int unsigned NUM_PHY      = 2,
  parameter int unsigned RST_CYCLES   = 500000,
  parameter int unsigned HOLD_CYCLES  = 50,
  parameter int unsigned READY_CYCLES = 250000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic              clk_50,
  input  logic              reset_n,
  phy_init_multi_if.slave   bus
);

  logic [NUM_PHY-1:0]         hw_rst;
  logic [NUM_PHY-1:0]         strap_oe;
  logic [NUM_PHY*STRAP_W-1:0] strap_out;
  logic [NUM_PHY-1:0]         ready;
  logic                       all_ready_q;

  for (genvar i = 0; i < NUM_PHY; i++) begin : g_chan
    phy_strap_seq #(
      .RST_CYCLES  (RST_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .READY_CYCLES(READY_CYCLES),
      .CNT_W       (CNT_W)
    ) u_seq (
      .clk_50       (clk_50),
      .reset_n      (reset_n),
      .chan_en      (bus.chan_en[i]),
      .reinit_req   (bus.reinit_req[i]),
      .strap_cfg    (bus.strap_cfg[i*STRAP_W +: STRAP_W]),
      .phy_hw_rst   (hw_rst[i]),
      .phy_strap_oe (strap_oe[i]),
      .phy_strap_out(strap_out[i*STRAP_W +: STRAP_W]),
      .phy_ready    (ready[i])
    );
  end

  // Disabled channels are masked out; with nothing enabled the flag stays low.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= (|bus.chan_en) && (&(ready | ~bus.chan_en));
    end
  end

  assign bus.phy_hw_rst    = hw_rst;
  assign bus.phy_strap_oe  = strap_oe;
  assign bus.phy_strap_out = strap_out;
  assign bus.phy_ready     = ready;
  assign bus.all_ready     = all_ready_q;

endmodule
